// File: rtl/div_seq_if.sv
// Handshake and operand bundle between the EX stage (master) and the divider sequencer (slave).
interface div_seq_if #(
  parameter int WIDTH = 32
);
  logic                 signed_div_i;
  logic [WIDTH-1:0]     opdata1_i;
  logic [WIDTH-1:0]     opdata2_i;
  logic                 start_i;
  logic                 annul_i;
  logic [2*WIDTH-1:0]   result_o;
  logic                 ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/div_seq.sv
// div_seq: multi-cycle restoring divider returning {remainder, quotient} for HI/LO.
// Optional macro DIV_ZERO_DIVIDEND_EN routes a zero dividend through the one-cycle BYZERO path.
module div_seq #(
  parameter int WIDTH = 32
) (
  input  logic      clk,
  input  logic      rst,
  div_seq_if.slave  bus
);

  localparam int             CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH);

  typedef enum logic [1:0] {
    S_FREE,
    S_BYZERO,
    S_ON,
    S_END
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0]    quo_q, quo_d;   // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0]    rem_q, rem_d;
  logic [WIDTH-1:0]    dsr_q, dsr_d;
  logic                neg_quo_q, neg_quo_d;
  logic                neg_rem_q, neg_rem_d;
  logic [2*WIDTH-1:0]  result_q, result_d;
  logic                ready_q, ready_d;

  logic                op1_neg, op2_neg;
  logic [WIDTH-1:0]    op1_mag, op2_mag;
  logic                fast_path;
  logic [WIDTH:0]      trial;
  logic [WIDTH-1:0]    quo_fix, rem_fix;

  assign op1_neg = bus.signed_div_i & bus.opdata1_i[WIDTH-1];
  assign op2_neg = bus.signed_div_i & bus.opdata2_i[WIDTH-1];
  assign op1_mag = op1_neg ? -bus.opdata1_i : bus.opdata1_i;
  assign op2_mag = op2_neg ? -bus.opdata2_i : bus.opdata2_i;

`ifdef DIV_ZERO_DIVIDEND_EN
  assign fast_path = (bus.opdata2_i == '0) || (bus.opdata1_i == '0);
`else
  assign fast_path = (bus.opdata2_i == '0);
`endif

  // Partial remainder stays below the divisor, so a WIDTH+1 bit difference has its MSB as the borrow.
  assign trial   = {rem_q, quo_q[WIDTH-1]} - {1'b0, dsr_q};
  assign quo_fix = neg_quo_q ? -quo_q : quo_q;
  assign rem_fix = neg_rem_q ? -rem_q : rem_q;

  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the case infers a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dsr_d     = dsr_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    ready_d   = ready_q;

    if (bus.annul_i) begin
      state_d  = S_FREE;
      cnt_d    = '0;
      result_d = '0;
      ready_d  = 1'b0;
    end else begin
      unique case (state_q)
        S_FREE: begin
          result_d = '0;
          ready_d  = 1'b0;
          if (bus.start_i) begin
            quo_d     = op1_mag;
            dsr_d     = op2_mag;
            rem_d     = '0;
            cnt_d     = '0;
            neg_quo_d = op1_neg ^ op2_neg;
            neg_rem_d = op1_neg;
            state_d   = fast_path ? S_BYZERO : S_ON;
          end
        end

        S_BYZERO: begin
          result_d = '0;
          ready_d  = 1'b1;
          state_d  = S_END;
        end

        S_ON: begin
          if (cnt_q == LAST) begin
            result_d = {rem_fix, quo_fix};
            ready_d  = 1'b1;
            state_d  = S_END;
          end else begin
            rem_d = trial[WIDTH] ? {rem_q[WIDTH-2:0], quo_q[WIDTH-1]} : trial[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
            cnt_d = cnt_q + 1'b1;
          end
        end

        S_END: begin
          if (!bus.start_i) begin
            result_d = '0;
            ready_d  = 1'b0;
            state_d  = S_FREE;
          end
        end

        default: state_d = S_FREE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q   <= S_FREE;
      cnt_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dsr_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dsr_q     <= dsr_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign bus.result_o = result_q;
  assign bus.ready_o  = ready_q;

  a_ready_only_in_end: assert property (@(posedge clk) ready_q == (state_q == S_END));
  a_zero_when_idle:    assert property (@(posedge clk) !ready_q |-> (result_q == '0));
  a_count_bounded:     assert property (@(posedge clk) cnt_q <= LAST);

endmodule
